// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the word-addressed data RAM.
package data_memory_pkg;

  localparam int DEFAULT_WORDSIZE = 64;
  localparam int DEFAULT_SIZE     = 32;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2
  } mem_op_e;

  // Clear has priority over a write in the same cycle.
  function automatic mem_op_e decode_op(input logic rst_n, input logic we, input logic addr_ok);
    if (!rst_n) begin
      return OP_CLEAR;
    end
    if (we && addr_ok) begin
      return OP_WRITE;
    end
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: synchronous clear/write, combinational gated read.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int WORDSIZE = DEFAULT_WORDSIZE,
  parameter int SIZE     = DEFAULT_SIZE,
  localparam int AW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       addr,
  input  logic [WORDSIZE-1:0] data_input,
  input  logic                write_enable,
  input  logic                read,
  output logic [WORDSIZE-1:0] data_output
);

  logic [WORDSIZE-1:0] mem_q [SIZE];
  logic [WORDSIZE-1:0] mem_d [SIZE];
  logic                addr_ok;
  mem_op_e             op;

  // Only a non-power-of-two depth can see addresses past the last word.
  generate
    if (SIZE == (1 << AW)) begin : g_full_range
      assign addr_ok = 1'b1;
    end else begin : g_partial_range
      assign addr_ok = (int'(addr) < SIZE);
    end
  endgenerate

  assign op = decode_op(rst_n, write_enable, addr_ok);

  always_comb begin
    mem_d = mem_q;
    case (op)
      OP_CLEAR: begin
        for (int i = 0; i < SIZE; i++) begin
          mem_d[i] = '0;
        end
      end
      OP_WRITE: mem_d[addr] = data_input;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_output = (read && addr_ok) ? mem_q[addr] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Randomised scoreboard bench for data_memory against an array reference model.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic [4:0]  addr;
  logic [63:0] data_input;
  logic        write_enable;
  logic        read;
  logic [63:0] data_output;

  data_memory #(.WORDSIZE(64), .SIZE(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .data_input   (data_input),
    .write_enable (write_enable),
    .read         (read),
    .data_output  (data_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] ref_mem [32];
  logic [63:0] exp_q [$];
  string       name_q [$];
  event        sample_ev;
  int          total = 0;
  int          bad   = 0;

  localparam logic [63:0] W5   = 64'h0000_0000_0005_e3a7;
  localparam logic [63:0] W14  = 64'h0000_0000_001f_13a2;
  localparam logic [63:0] WDB  = 64'hDEAD_BEEF_0000_0001;

  // Expected output derived purely from the model and the current inputs.
  task automatic expect_now(input string nm);
    exp_q.push_back(read ? ref_mem[addr] : 64'h0);
    name_q.push_back(nm);
    -> sample_ev;
  endtask

  // One full clock: drive at negedge, check old value, edge, check new value.
  task automatic cycle(input logic r_n, input logic [4:0] a, input logic [63:0] d,
                       input logic w, input logic rd, input string nm);
    @(negedge clk);
    rst_n = r_n; addr = a; data_input = d; write_enable = w; read = rd;
    #1 expect_now({nm, "_pre"});
    @(posedge clk);
    if (!r_n) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 64'h0;
    end else if (w) begin
      ref_mem[a] = d;
    end
    #1 expect_now({nm, "_post"});
  endtask

  // Combinational read inside the low phase, with write disabled.
  task automatic probe(input logic [4:0] a, input logic rd, input string nm);
    @(negedge clk);
    rst_n = 1'b1; write_enable = 1'b0; addr = a; read = rd;
    #1 expect_now(nm);
    #2;
  endtask

  initial begin : monitor
    logic [63:0] e;
    string       n;
    forever begin
      @(sample_ev);
      #1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_underflow actual=%h", data_output);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (data_output !== e) begin
          bad++;
          $display("FAIL %s actual=%h expected=%h", n, data_output, e);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; addr = '0; data_input = '0; write_enable = 1'b0; read = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 64'h0;

    cycle(1'b0, 5'd0, 64'h0, 1'b1, 1'b0, "reset");
    probe(5'd0,  1'b1, "rst_rd0");
    probe(5'd5,  1'b1, "rst_rd5");
    probe(5'd14, 1'b1, "rst_rd14");
    probe(5'd31, 1'b1, "rst_rd31");

    cycle(1'b1, 5'd5, W5, 1'b1, 1'b0, "wr5");
    probe(5'd5, 1'b1, "rd5");
    cycle(1'b1, 5'd14, W14, 1'b1, 1'b0, "wr14");
    probe(5'd14, 1'b1, "rd14");
    probe(5'd5,  1'b1, "rd5_again");

    // Read gating toggled within one low phase.
    @(negedge clk);
    rst_n = 1'b1; write_enable = 1'b0; addr = 5'd5; read = 1'b0;
    #1 expect_now("gate_off");
    #2 read = 1'b1;
    #1 expect_now("gate_on");

    cycle(1'b1, 5'd5,  64'h0, 1'b0, 1'b1, "nowr5_a");
    cycle(1'b1, 5'd14, 64'h0, 1'b0, 1'b1, "nowr14_a");
    cycle(1'b1, 5'd5,  64'h0, 1'b0, 1'b1, "nowr5_b");
    cycle(1'b1, 5'd14, 64'h0, 1'b0, 1'b1, "nowr14_b");

    cycle(1'b1, 5'd14, WDB, 1'b1, 1'b1, "wthru14");
    cycle(1'b0, 5'd14, 64'h0, 1'b1, 1'b1, "reset2");
    probe(5'd5, 1'b1, "post_rst5");

    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 39) != 0), 5'($urandom_range(0, 31)),
            {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), "rand");
      if ($urandom_range(0, 3) == 0) probe(5'($urandom_range(0, 31)), 1'b1, "rand_probe");
    end

    #20;
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
